// File: rtl/compuertas_logicas_reg.sv
// Registered, parametrised two-input bitwise logic unit with valid/ready
// handshaking, an optional accumulator operand and a wrapping operation count.
module compuertas_logicas_reg #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] e0,
  input  logic [WIDTH-1:0] e1,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             ones,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_YES  = 3'd7
  } op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // A clear in the same cycle as an accumulate accept must already be
  // visible to the operation, so B sees ACC_INIT rather than the stale acc.
  assign acc_eff   = acc_clr ? ACC_INIT : acc;
  assign operand_b = acc_mode ? acc_eff : e1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    result = '0;
    unique case (op_t'(op))
      OP_AND:  result = e0 & operand_b;
      OP_OR:   result = e0 | operand_b;
      OP_XOR:  result = e0 ^ operand_b;
      OP_NAND: result = ~(e0 & operand_b);
      OP_NOR:  result = ~(e0 | operand_b);
      OP_XNOR: result = ~(e0 ^ operand_b);
      OP_NOT:  result = ~e0;
      OP_YES:  result = e0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (accept)
      state_next = FULL;
    else if (out_ready)
      state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      s        <= '0;
      zero     <= 1'b0;
      ones     <= 1'b0;
      acc      <= ACC_INIT;
      op_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        s        <= result;
        zero     <= (result == '0);
        ones     <= (result == '1);
        op_count <= op_count + CNT_W'(1);
      end
      if (accept && acc_mode)
        acc <= result;
      else if (acc_clr)
        acc <= ACC_INIT;
    end
  end

endmodule

// File: tb/tb_compuertas_logicas_reg.sv
// Scoreboard bench for compuertas_logicas_reg: a driver pushes expected results
// from a truth-table model, a monitor pops them as the DUT presents outputs.
module tb_compuertas_logicas_reg;

  localparam int         W      = 8;
  localparam int         CW     = 2;
  localparam logic [7:0] A_INIT = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  e0, e1;
  logic [2:0]    op;
  logic          acc_mode, acc_clr;
  logic          out_valid, out_ready;
  logic [W-1:0]  s;
  logic          zero, ones;
  logic [W-1:0]  acc;
  logic [CW-1:0] op_count;

  compuertas_logicas_reg #(.WIDTH(W), .ACC_INIT(A_INIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .e0(e0), .e1(e1), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .zero(zero),
    .ones(ones), .acc(acc), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         z;
    logic         o;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;

  // Reference state: what the DUT should hold after the upcoming edge.
  logic          exp_ov  = 1'b0;
  logic [W-1:0]  exp_acc = A_INIT;
  logic [CW-1:0] exp_cnt = '0;

  // Per-gate truth table indexed by {a_bit, b_bit}.
  logic [3:0] truth [8];
  initial begin
    truth[0] = 4'b1000; truth[1] = 4'b1110; truth[2] = 4'b0110; truth[3] = 4'b0111;
    truth[4] = 4'b0001; truth[5] = 4'b1001; truth[6] = 4'b0011; truth[7] = 4'b1100;
  end

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = truth[o];
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] o, input logic m, input logic c, input logic r);
    logic         rdy;
    logic [W-1:0] bb, res;
    exp_t         e;
    @(negedge clk);
    in_valid = v; e0 = a; e1 = b; op = o; acc_mode = m; acc_clr = c; out_ready = r;
    #1;
    rdy = !exp_ov || r;
    check("in_ready", in_ready, rdy);
    if (v && rdy) begin
      bb  = m ? (c ? A_INIT : exp_acc) : b;
      res = ref_op(o, a, bb);
      e.s = res; e.z = (res == 0); e.o = (res == {W{1'b1}});
      sb.push_back(e);
      exp_ov  = 1'b1;
      exp_cnt = exp_cnt + 1'b1;
      if (m) exp_acc = res;
      else if (c) exp_acc = A_INIT;
    end else begin
      if (r) exp_ov = 1'b0;
      if (c) exp_acc = A_INIT;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; e0 = 8'h5A; op = 3'd1; acc_mode = 1'b1; out_ready = 1'b0;
    exp_ov = 1'b0; exp_acc = A_INIT; exp_cnt = '0;
    sb.delete();
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_zero", zero, 0);
    check("rst_ones", ones, 0);
    check("rst_acc", acc, A_INIT);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_mode = 1'b0;
  endtask

  // Monitor: runs just after each edge and compares whatever the DUT presents.
  initial begin
    logic prev_v;
    exp_t last, e;
    prev_v = 1'b0;
    last.s = '0; last.z = 1'b0; last.o = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      check("out_valid", out_valid, exp_ov);
      check("acc", acc, exp_acc);
      check("op_count", op_count, exp_cnt);
      if (out_valid && (!prev_v || out_ready)) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow actual=result_presented expected=none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("s", s, e.s);
          check("zero", zero, e.z);
          check("ones", ones, e.o);
          last = e;
        end
      end else if (out_valid) begin
        check("s_held", s, last.s);
        check("zero_held", zero, last.z);
        check("ones_held", ones, last.o);
      end
      prev_v = out_valid;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; e0 = '0; e1 = '0; op = '0;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // All eight ops back to back: 81 E7 66 7E 18 99 3C C3.
    for (int i = 0; i < 8; i++) step(1, 8'hC3, 8'hA5, 3'(i), 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure, then drain and accept together.
    step(1, 8'hFF, 8'h0F, 3'd0, 0, 0, 1);
    repeat (3) step(1, 8'h12, 8'h34, 3'd5, 0, 0, 0);
    step(1, 8'hFF, 8'h0F, 3'd2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Accumulate with OR, then XOR back to zero.
    step(1, 8'h01, 8'hEE, 3'd1, 1, 0, 1);
    step(1, 8'h02, 8'hEE, 3'd1, 1, 0, 1);
    step(1, 8'h04, 8'hEE, 3'd1, 1, 0, 1);
    step(1, 8'h80, 8'hEE, 3'd1, 1, 0, 1);
    step(1, 8'h87, 8'hEE, 3'd2, 1, 0, 1);

    // Clear coinciding with an accumulate accept, then a bare clear.
    step(1, 8'h87, 8'h00, 3'd1, 1, 0, 1);
    step(1, 8'h10, 8'h00, 3'd1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Flags and counter wrap.
    step(1, 8'hFF, 8'h00, 3'd7, 0, 0, 1);
    step(1, 8'hAB, 8'h00, 3'd0, 0, 0, 1);
    step(1, 8'h0F, 8'hF0, 3'd1, 0, 0, 1);
    step(1, 8'h0F, 8'hF0, 3'd4, 0, 0, 1);
    step(1, 8'h55, 8'h55, 3'd5, 0, 0, 1);

    // Reset while stalled with valid data.
    step(1, 8'h3C, 8'hC3, 3'd2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Randomised traffic with random backpressure and accumulator control.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0));

    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
